// File: rtl/gpio_bank.sv
// gpio_bank: bus-attached GPIO peripheral with NCH synchronised input channels,
// per-channel sticky change flags, maskable level interrupt and a set/clear
// output register.
// Optional feature macro: GPIO_SNAPSHOT_EN. When it is defined, the CTRL
// register captures a coherent snapshot of all channels. Channel reads then
// return the snapshot instead of the live synchronised value.
module gpio_bank #(
   parameter int unsigned NCH         = 4,
   parameter int unsigned IWIDTH      = 12,
   parameter int unsigned OWIDTH      = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cs,
   input  logic                  we,
   input  logic [4:0]            addr,
   input  logic [31:0]           wdat,
   output logic [31:0]           rdat,
   input  logic [NCH*IWIDTH-1:0] gp_in,
   output logic [OWIDTH-1:0]     gp_out,
   output logic                  irq
);

   localparam int unsigned W = NCH * IWIDTH;

   localparam logic [4:0] ADDR_OUT  = 5'h10;
   localparam logic [4:0] ADDR_SET  = 5'h11;
   localparam logic [4:0] ADDR_CLR  = 5'h12;
   localparam logic [4:0] ADDR_CHG  = 5'h13;
   localparam logic [4:0] ADDR_IEN  = 5'h14;
   localparam logic [4:0] ADDR_CTRL = 5'h15;

   logic              wr_en, rd_en;
   logic [W-1:0]      sync_w;
   logic [W-1:0]      prev_q;
   logic [NCH-1:0]    chg_q, chg_d, chg_set;
   logic [NCH-1:0]    irq_en_q;
   logic [OWIDTH-1:0] gp_out_q, gp_out_d;
   logic [31:0]       rdat_q, rd_data;
   logic              irq_q;
   logic [NCH-1:0][IWIDTH-1:0] rd_src;

   assign wr_en = cs & we;
   assign rd_en = cs & ~we;

   generate
      if (SYNC_STAGES == 0) begin : g_bypass
         assign sync_w = gp_in;
      end else begin : g_sync
         logic [W-1:0] pipe_q [SYNC_STAGES];

         // Per-bit synchroniser chain; gives no multi-bit coherence
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int s = 0; s < SYNC_STAGES; s++) pipe_q[s] <= '0;
            end else begin
               pipe_q[0] <= gp_in;
               for (int s = 1; s < SYNC_STAGES; s++) pipe_q[s] <= pipe_q[s-1];
            end
         end

         assign sync_w = pipe_q[SYNC_STAGES-1];
      end
   endgenerate

   // Per-channel change detection against the previous synchronised sample
   always_comb begin
      chg_set = '0;
      for (int i = 0; i < NCH; i++) begin
         chg_set[i] = (sync_w[i*IWIDTH +: IWIDTH] != prev_q[i*IWIDTH +: IWIDTH]);
      end
   end

   // Sticky flags: a new change beats a same-cycle W1C
   always_comb begin
      chg_d = chg_q;
      if (wr_en && addr == ADDR_CHG) chg_d = chg_q & ~wdat[NCH-1:0];
      chg_d = chg_d | chg_set;
   end

   // Output register with plain, set and clear write ports
   always_comb begin
      gp_out_d = gp_out_q;
      if (wr_en) begin
         case (addr)
            ADDR_OUT: gp_out_d = wdat[OWIDTH-1:0];
            ADDR_SET: gp_out_d = gp_out_q | wdat[OWIDTH-1:0];
            ADDR_CLR: gp_out_d = gp_out_q & ~wdat[OWIDTH-1:0];
            default:  gp_out_d = gp_out_q;
         endcase
      end
   end

`ifdef GPIO_SNAPSHOT_EN
   logic [W-1:0] snap_q;
   logic         auto_q;
   logic         snap_take;

   assign snap_take = (wr_en && addr == ADDR_CTRL && wdat[0]) || (auto_q && (|chg_set));
   assign rd_src    = snap_q;

   // Snapshot storage and auto-snapshot control bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_q <= '0;
         auto_q <= 1'b0;
      end else begin
         if (snap_take) snap_q <= sync_w;
         if (wr_en && addr == ADDR_CTRL) auto_q <= wdat[1];
      end
   end
`else
   assign rd_src = sync_w;
`endif

   // Read data mux; unmapped addresses return zero
   always_comb begin
      rd_data = '0;
      if (addr < 5'(NCH)) begin
         for (int i = 0; i < NCH; i++) begin
            if (addr == 5'(i)) rd_data = 32'(rd_src[i]);
         end
      end else begin
         case (addr)
            ADDR_OUT:  rd_data = 32'(gp_out_q);
            ADDR_CHG:  rd_data = 32'(chg_q);
            ADDR_IEN:  rd_data = 32'(irq_en_q);
`ifdef GPIO_SNAPSHOT_EN
            ADDR_CTRL: rd_data = {30'd0, auto_q, 1'b0};
`endif
            default:   rd_data = '0;
         endcase
      end
   end

   // Architectural state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_q   <= '0;
         chg_q    <= '0;
         irq_en_q <= '0;
         gp_out_q <= '0;
         rdat_q   <= '0;
         irq_q    <= 1'b0;
      end else begin
         prev_q   <= sync_w;
         chg_q    <= chg_d;
         gp_out_q <= gp_out_d;
         irq_q    <= |(chg_q & irq_en_q);
         if (wr_en && addr == ADDR_IEN) irq_en_q <= wdat[NCH-1:0];
         if (rd_en) rdat_q <= rd_data;
      end
   end

   assign rdat   = rdat_q;
   assign gp_out = gp_out_q;
   assign irq    = irq_q;

endmodule
